// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer: tag/register/data widths and the entry record.
package reorder_buffer_pkg;

   typedef logic [3:0]  rob_index_type;
   typedef logic [4:0]  reg_index_type;
   typedef logic [31:0] data_type;
   typedef logic [31:0] addr_type;

   localparam int            ROB_SIZE  = 16;
   localparam rob_index_type FIRST_TAG = 4'd1;
   localparam rob_index_type LAST_TAG  = 4'd15;
   localparam logic [3:0]    FULL_MARK = 4'd14;

   typedef struct packed {
      logic          valid;
      logic          ready;
      reg_index_type rd;
      logic          is_branch;
      logic          pred_taken;
      logic          taken;
      addr_type      alt_pc;
      data_type      val;
   } rob_entry_t;

   // Tag 0 is reserved for "no dependency", so the ring runs 1..15.
   function automatic rob_index_type next_tag(input rob_index_type t);
      return (t == LAST_TAG) ? FIRST_TAG : t + 4'd1;
   endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Issue, CDB, commit and flush signals of the reorder buffer.
// ROB_QUERY_EN adds the decoder operand lookup ports.
interface reorder_buffer_if;
   import reorder_buffer_pkg::*;

   logic          issue_ready;
   reg_index_type issue_rd;
   logic          issue_is_branch;
   logic          issue_pred_taken;
   addr_type      issue_alt_pc;
   rob_index_type rob_next_index;
   logic          rob_full;

   logic          alu_cdb_valid;
   rob_index_type alu_cdb_rob_index;
   data_type      alu_cdb_val;
   logic          alu_cdb_taken;
   logic          lsb_cdb_valid;
   rob_index_type lsb_cdb_rob_index;
   data_type      lsb_cdb_val;

   logic          rob_to_reg_commit;
   rob_index_type rob_to_reg_rob_index;
   reg_index_type rob_to_reg_index;
   data_type      rob_to_reg_val;
   logic          rob_clr_out;
   addr_type      rob_clr_pc;

`ifdef ROB_QUERY_EN
   rob_index_type dc_rs1_tag;
   rob_index_type dc_rs2_tag;
   logic          rob_rs1_ready;
   logic          rob_rs2_ready;
   data_type      rob_rs1_val;
   data_type      rob_rs2_val;
`endif

   modport master (
      output issue_ready, issue_rd, issue_is_branch, issue_pred_taken, issue_alt_pc,
      output alu_cdb_valid, alu_cdb_rob_index, alu_cdb_val, alu_cdb_taken,
      output lsb_cdb_valid, lsb_cdb_rob_index, lsb_cdb_val,
      input  rob_next_index, rob_full,
      input  rob_to_reg_commit, rob_to_reg_rob_index, rob_to_reg_index, rob_to_reg_val,
      input  rob_clr_out, rob_clr_pc
`ifdef ROB_QUERY_EN
      , output dc_rs1_tag, dc_rs2_tag
      , input  rob_rs1_ready, rob_rs2_ready, rob_rs1_val, rob_rs2_val
`endif
   );

   modport slave (
      input  issue_ready, issue_rd, issue_is_branch, issue_pred_taken, issue_alt_pc,
      input  alu_cdb_valid, alu_cdb_rob_index, alu_cdb_val, alu_cdb_taken,
      input  lsb_cdb_valid, lsb_cdb_rob_index, lsb_cdb_val,
      output rob_next_index, rob_full,
      output rob_to_reg_commit, rob_to_reg_rob_index, rob_to_reg_index, rob_to_reg_val,
      output rob_clr_out, rob_clr_pc
`ifdef ROB_QUERY_EN
      , input  dc_rs1_tag, dc_rs2_tag
      , output rob_rs1_ready, rob_rs2_ready, rob_rs1_val, rob_rs2_val
`endif
   );

endinterface

// File: rtl/reorder_buffer.sv
// 15-entry in-order reorder buffer with one commit per cycle and mispredict flush.
// Define ROB_QUERY_EN to add combinational operand lookup for the decoder.
module reorder_buffer (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             rdy_in,
   reorder_buffer_if.slave  bus
);
   import reorder_buffer_pkg::*;

   rob_entry_t    entry [ROB_SIZE];
   rob_index_type head;
   rob_index_type tail;
   logic [3:0]    count;
   logic          head_commit;
   logic          head_mispredict;
   logic          do_issue;

   assign bus.rob_next_index = tail;
   assign bus.rob_full       = (count >= FULL_MARK);
   assign head_commit        = entry[head].valid && entry[head].ready;
   assign head_mispredict    = head_commit && entry[head].is_branch &&
                               (entry[head].pred_taken != entry[head].taken);
   assign do_issue           = bus.issue_ready && (count != LAST_TAG);

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < ROB_SIZE; i++) entry[i] <= '0;
         head                     <= FIRST_TAG;
         tail                     <= FIRST_TAG;
         count                    <= '0;
         bus.rob_to_reg_commit    <= 1'b0;
         bus.rob_to_reg_rob_index <= '0;
         bus.rob_to_reg_index     <= '0;
         bus.rob_to_reg_val       <= '0;
         bus.rob_clr_out          <= 1'b0;
         bus.rob_clr_pc           <= '0;
      end else if (rdy_in) begin
         bus.rob_to_reg_commit <= head_commit && (entry[head].rd != '0);
         bus.rob_clr_out       <= head_mispredict;
         if (head_commit) begin
            bus.rob_to_reg_rob_index <= head;
            bus.rob_to_reg_index     <= entry[head].rd;
            bus.rob_to_reg_val       <= entry[head].val;
         end
         if (head_mispredict) begin
            // Flush wins over everything else arriving in this cycle.
            bus.rob_clr_pc <= entry[head].alt_pc;
            for (int i = 0; i < ROB_SIZE; i++) entry[i].valid <= 1'b0;
            head  <= FIRST_TAG;
            tail  <= FIRST_TAG;
            count <= '0;
         end else begin
            // LSB first so a same-tag ALU write overrides it.
            if (bus.lsb_cdb_valid && entry[bus.lsb_cdb_rob_index].valid) begin
               entry[bus.lsb_cdb_rob_index].ready <= 1'b1;
               entry[bus.lsb_cdb_rob_index].val   <= bus.lsb_cdb_val;
            end
            if (bus.alu_cdb_valid && entry[bus.alu_cdb_rob_index].valid) begin
               entry[bus.alu_cdb_rob_index].ready <= 1'b1;
               entry[bus.alu_cdb_rob_index].val   <= bus.alu_cdb_val;
               entry[bus.alu_cdb_rob_index].taken <= bus.alu_cdb_taken;
            end
            if (head_commit) begin
               entry[head].valid <= 1'b0;
               head              <= next_tag(head);
            end
            if (do_issue) begin
               entry[tail] <= '{valid: 1'b1, ready: 1'b0, rd: bus.issue_rd,
                                is_branch: bus.issue_is_branch,
                                pred_taken: bus.issue_pred_taken, taken: 1'b0,
                                alt_pc: bus.issue_alt_pc, val: '0};
               tail        <= next_tag(tail);
            end
            count <= count + 4'(do_issue) - 4'(head_commit);
         end
      end else begin
         bus.rob_to_reg_commit <= 1'b0;
         bus.rob_clr_out       <= 1'b0;
      end
   end

`ifdef ROB_QUERY_EN
   // {ready, value}: a stored result first, else a result on the CDB this cycle.
   function automatic logic [32:0] lookup(input rob_index_type tag);
      logic [32:0] r;
      r = '0;
      if (entry[tag].valid) begin
         if (entry[tag].ready)
            r = {1'b1, entry[tag].val};
         else if (bus.alu_cdb_valid && bus.alu_cdb_rob_index == tag)
            r = {1'b1, bus.alu_cdb_val};
         else if (bus.lsb_cdb_valid && bus.lsb_cdb_rob_index == tag)
            r = {1'b1, bus.lsb_cdb_val};
      end
      return r;
   endfunction

   assign {bus.rob_rs1_ready, bus.rob_rs1_val} = lookup(bus.dc_rs1_tag);
   assign {bus.rob_rs2_ready, bus.rob_rs2_val} = lookup(bus.dc_rs2_tag);
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Random plus directed stimulus against a queue-based reorder buffer model with a commit scoreboard.
module tb_reorder_buffer;
   import reorder_buffer_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic rdy;
   always #5 clk = ~clk;

   reorder_buffer_if bus();
   reorder_buffer dut (.clk_in(clk), .rst_in(rst), .rdy_in(rdy), .bus(bus));

   typedef struct {
      int          tag;
      int          rd;
      bit          br;
      bit          pred;
      bit          taken;
      bit          ready;
      int unsigned alt;
      int unsigned val;
   } m_ent_t;

   typedef struct {
      int          cyc;
      bit          commit;
      int          tag;
      int          rd;
      int unsigned val;
      bit          clr;
      int unsigned pc;
   } ev_t;

   m_ent_t mq[$];
   ev_t    expq[$];
   ev_t    mon_e;
   int     m_tail = 1;
   int     total = 0;
   int     bad = 0;
   int     cyc = 0;

   bit          s_rst, s_rdy, s_iss, s_br, s_pred, s_av, s_at, s_lv;
   int          s_rd, s_ai, s_li;
   int unsigned s_alt, s_aval, s_lval;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int want);
      total++;
      if (act != want) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, want);
      end
   endtask

   // Scoreboard monitor: every commit/flush pulse must match the oldest expected event.
   always @(negedge clk) begin
      if (bus.rob_to_reg_commit === 1'b1 || bus.rob_clr_out === 1'b1) begin
         total++;
         if (expq.size() == 0) begin
            bad++;
            $display("FAIL unexpected_pulse cyc=%0d commit=%0b clr=%0b tag=%0d", cyc,
                     bus.rob_to_reg_commit, bus.rob_clr_out, bus.rob_to_reg_rob_index);
         end else begin
            mon_e = expq.pop_front();
            if (mon_e.cyc != cyc || mon_e.commit != bus.rob_to_reg_commit ||
                mon_e.clr != bus.rob_clr_out ||
                (mon_e.commit && (mon_e.tag != int'(bus.rob_to_reg_rob_index) ||
                                  mon_e.rd != int'(bus.rob_to_reg_index) ||
                                  mon_e.val != bus.rob_to_reg_val)) ||
                (mon_e.clr && mon_e.pc != bus.rob_clr_pc)) begin
               bad++;
               $display("FAIL commit_event cyc=%0d got commit=%0b tag=%0d rd=%0d val=%h clr=%0b pc=%h want cyc=%0d commit=%0b tag=%0d rd=%0d val=%h clr=%0b pc=%h",
                        cyc, bus.rob_to_reg_commit, bus.rob_to_reg_rob_index, bus.rob_to_reg_index,
                        bus.rob_to_reg_val, bus.rob_clr_out, bus.rob_clr_pc, mon_e.cyc, mon_e.commit,
                        mon_e.tag, mon_e.rd, mon_e.val, mon_e.clr, mon_e.pc);
            end
         end
      end else if (expq.size() > 0 && expq[0].cyc <= cyc) begin
         total++;
         bad++;
         mon_e = expq.pop_front();
         $display("FAIL missing_pulse cyc=%0d got=none want tag=%0d commit=%0b clr=%0b",
                  cyc, mon_e.tag, mon_e.commit, mon_e.clr);
      end
   end

   // Reference model: the buffer is a queue of in-flight entries, oldest first.
   task automatic model_edge();
      ev_t    e;
      m_ent_t n;
      int     pre;
      bit     commit, mis;
      if (s_rst) begin
         mq.delete();
         m_tail = 1;
         return;
      end
      if (!s_rdy) return;
      pre    = mq.size();
      commit = (pre > 0) && mq[0].ready;
      mis    = commit && mq[0].br && (mq[0].pred != mq[0].taken);
      if (commit && (mq[0].rd != 0 || mis)) begin
         e.cyc = cyc + 1; e.commit = (mq[0].rd != 0); e.tag = mq[0].tag; e.rd = mq[0].rd;
         e.val = mq[0].val; e.clr = mis; e.pc = mq[0].alt;
         expq.push_back(e);
      end
      if (mis) begin
         mq.delete();
         m_tail = 1;
         return;
      end
      foreach (mq[i]) if (s_lv && mq[i].tag == s_li) begin mq[i].ready = 1; mq[i].val = s_lval; end
      foreach (mq[i]) if (s_av && mq[i].tag == s_ai) begin
         mq[i].ready = 1; mq[i].val = s_aval; mq[i].taken = s_at;
      end
      if (commit) void'(mq.pop_front());
      if (s_iss && pre < 15) begin
         n.tag = m_tail; n.rd = s_rd; n.br = s_br; n.pred = s_pred; n.taken = 0;
         n.ready = 0; n.alt = s_alt; n.val = 0;
         mq.push_back(n);
         m_tail = m_tail % 15 + 1;
      end
   endtask

   task automatic step();
      @(negedge clk);
      chk("rob_full", int'(bus.rob_full), int'(mq.size() >= 14));
      chk("rob_next_index", int'(bus.rob_next_index), m_tail);
      rst = s_rst;
      rdy = s_rdy;
      bus.issue_ready       = s_iss;
      bus.issue_rd          = 5'(s_rd);
      bus.issue_is_branch   = s_br;
      bus.issue_pred_taken  = s_pred;
      bus.issue_alt_pc      = s_alt;
      bus.alu_cdb_valid     = s_av;
      bus.alu_cdb_rob_index = 4'(s_ai);
      bus.alu_cdb_val       = s_aval;
      bus.alu_cdb_taken     = s_at;
      bus.lsb_cdb_valid     = s_lv;
      bus.lsb_cdb_rob_index = 4'(s_li);
      bus.lsb_cdb_val       = s_lval;
      model_edge();
   endtask

   task automatic clr_s();
      s_rst = 0; s_rdy = 1; s_iss = 0; s_br = 0; s_pred = 0; s_av = 0; s_at = 0; s_lv = 0;
      s_rd = 0; s_ai = 0; s_li = 0; s_alt = 0; s_aval = 0; s_lval = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin clr_s(); step(); end
   endtask

   task automatic reset_dut();
      clr_s(); s_rst = 1; step();
      @(posedge clk); #1;
      chk("reset_commit", int'(bus.rob_to_reg_commit), 0);
      chk("reset_clr", int'(bus.rob_clr_out), 0);
   endtask

   task automatic issue(input int rd, input bit br = 0, input bit pred = 0, input int unsigned alt = 0);
      clr_s(); s_iss = 1; s_rd = rd; s_br = br; s_pred = pred; s_alt = alt; step();
   endtask

   task automatic alu(input int tag, input int unsigned v, input bit tk = 0);
      clr_s(); s_av = 1; s_ai = tag; s_aval = v; s_at = tk; step();
   endtask

   function automatic int pick_tag();
      if (mq.size() > 0 && $urandom_range(0, 99) < 80) return mq[$urandom_range(0, mq.size() - 1)].tag;
      return int'($urandom_range(0, 15));
   endfunction

   initial begin
      clr_s();
      rst = 1; rdy = 1;
      bus.issue_ready = 0; bus.issue_rd = 0; bus.issue_is_branch = 0; bus.issue_pred_taken = 0;
      bus.issue_alt_pc = 0; bus.alu_cdb_valid = 0; bus.alu_cdb_rob_index = 0; bus.alu_cdb_val = 0;
      bus.alu_cdb_taken = 0; bus.lsb_cdb_valid = 0; bus.lsb_cdb_rob_index = 0; bus.lsb_cdb_val = 0;
      repeat (2) @(posedge clk);

      // Basic issue / writeback / commit latency
      reset_dut();
      issue(5);
      idle(1);
      alu(1, 32'h1234);
      idle(3);

      // Fill to capacity, overflow issue ignored, wrap of tags
      reset_dut();
      for (int i = 1; i <= 16; i++) issue(i);
      alu(1, 32'h77);
      idle(2);
      issue(9);
      idle(1);

      // Out-of-order writeback, in-order commit
      reset_dut();
      issue(1); issue(2); issue(3);
      alu(3, 32'h3); alu(2, 32'h2); alu(1, 32'h1);
      idle(4);

      // Both CDBs on the same tag: ALU value wins
      reset_dut();
      for (int i = 1; i <= 4; i++) issue(10 + i);
      alu(1, 1); alu(2, 2); alu(3, 3);
      clr_s(); s_av = 1; s_ai = 4; s_aval = 32'hA; s_lv = 1; s_li = 4; s_lval = 32'hB; step();
      idle(4);

      // Mispredicted branch behind a normal entry
      reset_dut();
      issue(1); issue(0, 1, 0, 32'h100); issue(3);
      alu(1, 32'h11); alu(2, 32'h0, 1);
      idle(3);
      issue(7);
      idle(1);

      // Stall with a ready head
      reset_dut();
      issue(6);
      alu(1, 32'h66);
      repeat (5) begin clr_s(); s_rdy = 0; s_av = 1; s_ai = 1; s_aval = 32'hDEAD; step(); end
      idle(3);

      // Reset while a commit is pending
      reset_dut();
      issue(8); issue(9);
      alu(1, 32'h8);
      reset_dut();
      idle(3);

      // Random traffic
      for (int k = 0; k < 3000; k++) begin
         int r;
         clr_s();
         r = int'($urandom_range(0, 99));
         if (r < 1) s_rst = 1;
         else if (r < 8) s_rdy = 0;
         s_iss  = ($urandom_range(0, 99) < 55);
         s_rd   = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 31));
         s_br   = ($urandom_range(0, 9) == 0);
         s_pred = 1'($urandom_range(0, 1));
         s_alt  = $urandom;
         s_av   = ($urandom_range(0, 99) < 60);
         s_ai   = pick_tag();
         s_aval = $urandom;
         s_at   = 1'($urandom_range(0, 1));
         s_lv   = ($urandom_range(0, 99) < 40);
         s_li   = pick_tag();
         s_lval = $urandom;
         step();
      end
      idle(3);
      @(negedge clk);
      @(negedge clk);
      chk("scoreboard_drained", expq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk_in (input, 1, clock) and rst_in (input, 1, synchronous active-high reset).
REQ-002 rdy_in  input  1  global enable; low freezes all state.
REQ-003 issue_ready  input  1  allocate one entry this cycle.
REQ-004 issue_rd  input  5  destination register; 0 = none.
REQ-005 issue_is_branch, issue_pred_taken  input  1 each  branch flag and predicted direction.
REQ-006 issue_alt_pc  input  32  PC to redirect to if the prediction is wrong.
REQ-007 rob_next_index  output  4  tag the next issued entry receives.
REQ-008 rob_full  output  1  issue prohibited.
REQ-009 alu_cdb_valid / alu_cdb_rob_index (4) / alu_cdb_val (32) / alu_cdb_taken (1)  input  ALU writeback.
REQ-010 lsb_cdb_valid / lsb_cdb_rob_index (4) / lsb_cdb_val (32)  input  load writeback.
REQ-011 rob_to_reg_commit (1), rob_to_reg_rob_index (4), rob_to_reg_index (5), rob_to_reg_val (32)  output  register commit.
REQ-012 rob_clr_out (1), rob_clr_pc (32)  output  mispredict flush pulse and redirect PC.

Function
REQ-013 Tags SHALL run 1..15 (15 entries); tag 0 means "no dependency" and SHALL never be allocated.
REQ-014 Head and tail SHALL wrap from 15 to 1.
REQ-015 rob_next_index SHALL equal the tail tag.
REQ-016 rob_full SHALL be combinational and high when count >= 14, leaving one slot of slack for the registered issue stage.
REQ-017 An issue_ready pulse in cycle t SHALL fill the tail entry (valid=1, ready=0) at the cycle-t edge, and the tail SHALL advance.
REQ-018 An issue while count==15 SHALL be ignored.
REQ-019 A CDB write in cycle t SHALL set ready and store the value (and taken flag for ALU) at the cycle-t edge.
REQ-020 A CDB write to an invalid entry SHALL be ignored.
REQ-021 If both CDBs target the same tag in one cycle, the ALU CDB SHALL win.
REQ-022 At most one commit per cycle: if the head is valid and ready at an edge, the head SHALL retire and the commit outputs SHALL be registered high for exactly one cycle.
REQ-023 Latency: CDB valid in cycle t SHALL give rob_to_reg_commit high in cycle t+2 when that entry is the head.
REQ-024 A commit with rd==0 SHALL retire without asserting rob_to_reg_commit.
REQ-025 Simultaneous issue and commit SHALL leave count unchanged.
REQ-026 Committing a branch whose pred_taken != taken SHALL make the following happen in the same retiring edge:
- rob_clr_out is high for one cycle and rob_clr_pc = alt_pc.
- All entries are invalidated, head = tail = 1, count = 0.
- Any issue or CDB write in that cycle is discarded.
REQ-027 A correctly predicted branch SHALL retire silently.
REQ-028 With rdy_in low, all state SHALL hold and the commit and clear pulses SHALL be 0.

Reset
REQ-029 On rst_in: all entries invalid, head = tail = 1, count = 0, and every output register 0.
REQ-030 Reset resulting outputs: rob_full = 0, rob_next_index = 1.
REQ-031 Reset mid-operation SHALL discard in-flight entries with no commit pulse.
REQ-032 Reset SHALL override rdy_in.

Configuration
REQ-033 With ROB_QUERY_EN defined, the block SHALL add the following ports:
- Inputs dc_rs1_tag and dc_rs2_tag (4 each).
- Outputs rob_rs1_ready / rob_rs2_ready (1) and rob_rs1_val / rob_rs2_val (32).
- Combinational behaviour: ready=1 and val=entry value when the tag is valid and ready; ready=1 and val=CDB value when a same-cycle CDB write targets it (ALU priority); otherwise 0.
REQ-034 Without ROB_QUERY_EN those ports SHALL be absent, and the decoder waits for CDB broadcast.

Structure
REQ-035 The shared defines header SHALL hold ROB_INDEX_TYPE [3:0], ROB_SIZE 16, REG_INDEX_TYPE [4:0], DATA_TYPE [31:0] and ADDR_TYPE [31:0].
REQ-036 There SHALL be no sub-module: a single module holding the entry arrays and the head/tail/count registers.

Verification
REQ-037 Scenario 1: after reset, issue rd=5 -> tag 1; ALU CDB tag 1 val 0x1234 at cycle t -> commit at t+2 with index 5, tag 1, val 0x1234.
REQ-038 Scenario 2: issue 15 entries with no writeback -> rob_full high from count 14; the 16th issue is ignored; rob_next_index wraps 15 -> 1 after one commit.
REQ-039 Scenario 3: write back tags 3, 2, 1 in that order -> commits occur in order 1, 2, 3 on consecutive cycles.
REQ-040 Scenario 4: ALU and LSB both target tag 4 with 0xA / 0xB -> committed val 0xA.
REQ-041 Scenario 5: branch at tag 2 with pred 0, taken 1, alt_pc 0x100 behind valid entry 1 -> entry 1 commits, then rob_clr_out pulses with pc 0x100, and the next issue gets tag 1.
REQ-042 Scenario 6: hold rdy_in low for 5 cycles with a ready head -> no commit; commit occurs on the first cycle after rdy_in returns high.
